// File: rtl/vga_sync_decoder.sv
// Receive-side timing recovery: rebuilds hcount/vcount/blanks from incoming syncs,
// checks each sync edge against the expected timing and reports lock.
module vga_sync_decoder #(
    parameter int HOR_TOTAL_TIME  = 1344,
    parameter int HOR_BLANK_START = 1024,
    parameter int HOR_SYNC_START  = 1048,
    parameter int HOR_SYNC_END    = 1184,
    parameter int VER_TOTAL_TIME  = 806,
    parameter int VER_BLANK_START = 768,
    parameter int VER_SYNC_START  = 771,
    parameter int VER_SYNC_END    = 777,
    parameter bit SYNC_ACT_HIGH   = 1'b1,
    parameter int LOCK_FRAMES     = 2,
    parameter int TIMEOUT_CYCLES  = 2 * HOR_TOTAL_TIME
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        locked,
    output logic        sync_err
);

    localparam logic        SYNC_INV   = ~SYNC_ACT_HIGH;
    localparam logic [10:0] H_LAST     = 11'(HOR_TOTAL_TIME - 1);
    localparam logic [10:0] H_BLANK    = 11'(HOR_BLANK_START);
    localparam logic [10:0] H_SYNC_LD  = 11'(HOR_SYNC_START);
    localparam logic [10:0] H_SYNC_PRE = 11'(HOR_SYNC_START - 1);
    localparam logic [10:0] H_END_PRE  = 11'(HOR_SYNC_END - 1);
    localparam logic [10:0] V_LAST     = 11'(VER_TOTAL_TIME - 1);
    localparam logic [10:0] V_BLANK    = 11'(VER_BLANK_START);
    localparam logic [10:0] V_SYNC_LD  = 11'(VER_SYNC_START);
    localparam logic [10:0] V_SYNC_PRE = 11'(VER_SYNC_START - 1);
    localparam logic [10:0] V_END_PRE  = 11'(VER_SYNC_END - 1);
    localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam int          GW         = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   h_q, h_d;
    logic [10:0]   v_q, v_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] good_q, good_d;
    logic          hs_q, vs_q;
    logic          err_q, err_d;

    logic hs, vs, hs_rise, hs_fall, vs_rise, vs_fall, h_wrap;

    assign hs      = hsync_in ^ SYNC_INV;
    assign vs      = vsync_in ^ SYNC_INV;
    assign hs_rise = hs & ~hs_q;
    assign hs_fall = ~hs & hs_q;
    assign vs_rise = vs & ~vs_q;
    assign vs_fall = ~vs & vs_q;
    assign h_wrap  = (h_q == H_LAST);

    // A leading sync edge realigns the counter, overriding the normal wrap.
    always_comb begin
        if (hs_rise) begin
            h_d = H_SYNC_LD;
        end else if (h_wrap) begin
            h_d = '0;
        end else begin
            h_d = h_q + 11'd1;
        end

        v_d = v_q;
        if (vs_rise) begin
            v_d = V_SYNC_LD;
        end else if (h_wrap && !hs_rise) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
        end
    end

    // Edge checks look at the counts before this cycle's update.
    always_comb begin
        err_d = 1'b0;
        if (state_q != ST_UNLOCKED) begin
            if (hs_rise && (h_q != H_SYNC_PRE)) err_d = 1'b1;
            if (hs_fall && (h_q != H_END_PRE))  err_d = 1'b1;
            if (vs_rise && ((v_q != V_SYNC_PRE) || !h_wrap)) err_d = 1'b1;
            if (vs_fall && ((v_q != V_END_PRE)  || !h_wrap)) err_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (hs_rise) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (tmo_d == TMO_MAX) begin
            state_d = ST_UNLOCKED;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (vs_rise) begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (err_d) begin
                        good_d = '0;
                    end else if (vs_rise) begin
                        good_d = good_q + GW'(1);
                        if (good_q + GW'(1) == GOOD_MAX) state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (err_d) begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
            h_q     <= '0;
            v_q     <= '0;
            tmo_q   <= '0;
            good_q  <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            tmo_q   <= tmo_d;
            good_q  <= good_d;
            hs_q    <= hs;
            vs_q    <= vs;
            err_q   <= err_d;
        end
    end

    assign hcount_out = h_q;
    assign vcount_out = v_q;
    assign hblnk_out  = (h_q >= H_BLANK);
    assign vblnk_out  = (v_q >= V_BLANK);
    assign locked     = (state_q == ST_LOCKED);
    assign sync_err   = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomised sync streams with disruptions; a time-based reference model feeds a
// scoreboard queue that a monitor drains every cycle for both sync polarities.
module tb_vga_sync_decoder;

    localparam int HT = 40, HBS = 32, HSS = 34, HSE = 37;
    localparam int VT = 12, VBS = 9, VSS = 10, VSE = 11;
    localparam int LF = 2, TO = 2 * HT;
    localparam int M_UNL = 0, M_ACQ = 1, M_LCK = 2;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic        lk;
        logic        se;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_drv = 1'b0, vs_drv = 1'b0;
    logic hs_lo, vs_lo;
    logic [10:0] hc_hi, vc_hi, hc_lo, vc_lo;
    logic hb_hi, vb_hi, lk_hi, se_hi, hb_lo, vb_lo, lk_lo, se_lo;

    assign hs_lo = ~hs_drv;
    assign vs_lo = ~vs_drv;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .HOR_TOTAL_TIME(HT), .HOR_BLANK_START(HBS), .HOR_SYNC_START(HSS), .HOR_SYNC_END(HSE),
        .VER_TOTAL_TIME(VT), .VER_BLANK_START(VBS), .VER_SYNC_START(VSS), .VER_SYNC_END(VSE),
        .SYNC_ACT_HIGH(1'b1), .LOCK_FRAMES(LF), .TIMEOUT_CYCLES(TO)
    ) dut_hi (
        .clk(clk), .rst(rst), .hsync_in(hs_drv), .vsync_in(vs_drv),
        .hcount_out(hc_hi), .vcount_out(vc_hi), .hblnk_out(hb_hi), .vblnk_out(vb_hi),
        .locked(lk_hi), .sync_err(se_hi)
    );

    vga_sync_decoder #(
        .HOR_TOTAL_TIME(HT), .HOR_BLANK_START(HBS), .HOR_SYNC_START(HSS), .HOR_SYNC_END(HSE),
        .VER_TOTAL_TIME(VT), .VER_BLANK_START(VBS), .VER_SYNC_START(VSS), .VER_SYNC_END(VSE),
        .SYNC_ACT_HIGH(1'b0), .LOCK_FRAMES(LF), .TIMEOUT_CYCLES(TO)
    ) dut_lo (
        .clk(clk), .rst(rst), .hsync_in(hs_lo), .vsync_in(vs_lo),
        .hcount_out(hc_lo), .vcount_out(vc_lo), .hblnk_out(hb_lo), .vblnk_out(vb_lo),
        .locked(lk_lo), .sync_err(se_lo)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position is the last anchor plus elapsed edges, folded by
    // the line and frame lengths; anchors are re-taken at sync leading edges.
    int t, ta, ha, va, mt, g, ms;
    bit hsp, vsp;
    int th, tv;

    task automatic compare(input string name, input exp_t act, input exp_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got h=%0d v=%0d hb=%0b vb=%0b lk=%0b se=%0b, want h=%0d v=%0d hb=%0b vb=%0b lk=%0b se=%0b",
                     name, $time, act.h, act.v, act.hb, act.vb, act.lk, act.se,
                     e.h, e.v, e.hb, e.vb, e.lk, e.se);
        end
    endtask

    task automatic model_edge(input bit r, input bit hs, input bit vs);
        exp_t e;
        int ph, pv, nh, nv;
        bit hr, hf, vr, vf, err;
        e = '0;
        if (r) begin
            t = 0; ta = 0; ha = 0; va = 0; mt = 0; g = 0; ms = M_UNL;
            hsp = 1'b0; vsp = 1'b0;
        end else begin
            hr = hs && !hsp;
            hf = !hs && hsp;
            vr = vs && !vsp;
            vf = !vs && vsp;
            ph = (ha + t - ta) % HT;
            pv = (va + (ha + t - ta) / HT) % VT;
            err = 1'b0;
            if (ms != M_UNL) begin
                err = (hr && ph != HSS - 1) || (hf && ph != HSE - 1) ||
                      (vr && (pv != VSS - 1 || ph != HT - 1)) ||
                      (vf && (pv != VSE - 1 || ph != HT - 1));
            end
            t++;
            if (vr) begin
                ta = t; ha = hr ? HSS : (ph + 1) % HT; va = VSS;
            end else if (hr) begin
                ta = t; ha = HSS; va = pv;
            end
            nh = (ha + t - ta) % HT;
            nv = (va + (ha + t - ta) / HT) % VT;
            mt = hr ? 0 : ((mt < TO) ? mt + 1 : mt);
            if (mt >= TO) begin
                ms = M_UNL;
            end else if (ms == M_UNL) begin
                if (vr) begin ms = M_ACQ; g = 0; end
            end else if (err) begin
                ms = M_ACQ; g = 0;
            end else if (ms == M_ACQ && vr) begin
                g++;
                if (g == LF) ms = M_LCK;
            end
            hsp = hs;
            vsp = vs;
            e.h  = 11'(nh);
            e.v  = 11'(nv);
            e.hb = (nh >= HBS);
            e.vb = (nv >= VBS);
            e.lk = (ms == M_LCK);
            e.se = err;
        end
        exp_q.push_back(e);
    endtask

    // mode 0: normal hsync, 1: held inactive, 2: forced active
    task automatic tx_cycle(input int hend, input int mode, input bit r);
        bit hs, vs;
        hs = (th >= HSS) && (th < hend);
        if (mode == 1) hs = 1'b0;
        if (mode == 2) hs = 1'b1;
        vs = (tv >= VSS) && (tv < VSE);
        @(negedge clk);
        rst    = r;
        hs_drv = hs;
        vs_drv = vs;
        model_edge(r, hs, vs);
        th++;
        if (th == HT) begin
            th = 0;
            tv = (tv + 1) % VT;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tx_cycle(HSE, 0, 1'b0);
    endtask

    task automatic align_to(input int pos);
        for (int i = 0; i < HT && th != pos; i++) tx_cycle(HSE, 0, 1'b0);
    endtask

    task automatic check_async_reset();
        exp_t act;
        #1;
        act = {hc_hi, vc_hi, hb_hi, vb_hi, lk_hi, se_hi};
        compare("async_reset_hi", act, '0);
        act = {hc_lo, vc_lo, hb_lo, vb_lo, lk_lo, se_lo};
        compare("async_reset_lo", act, '0);
    endtask

    // Monitor: one expected record per clock edge, checked 1 time unit after it.
    initial begin
        exp_t e, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {hc_hi, vc_hi, hb_hi, vb_hi, lk_hi, se_hi};
                compare("stream_hi", act, e);
                act = {hc_lo, vc_lo, hb_lo, vb_lo, lk_lo, se_lo};
                compare("stream_lo", act, e);
            end
        end
    end

    initial begin
        int sc, n;
        th = $urandom_range(0, HT - 1);
        tv = $urandom_range(0, VT - 1);
        for (int i = 0; i < 3; i++) tx_cycle(HSE, 0, 1'b1);
        check_async_reset();
        run_cycles(4 * HT * VT);
        $display("clean start: locked=%0b compared=%0d", lk_hi, n_cmp);

        for (int it = 0; it < 14; it++) begin
            sc = (it < 6) ? it : $urandom_range(0, 5);
            case (sc)
                1: begin
                    align_to(5);
                    th = th + 1;
                end
                2: begin
                    n = ($urandom_range(0, 1) == 0) ? (TO - 1 + $urandom_range(0, 2))
                                                    : $urandom_range(HT, 3 * HT);
                    for (int i = 0; i < n; i++) tx_cycle(HSE, 1, 1'b0);
                end
                3: begin
                    align_to(0);
                    for (int i = 0; i < HT; i++) tx_cycle(HSE - 1, 0, 1'b0);
                end
                4: begin
                    run_cycles($urandom_range(0, HT * VT));
                    tx_cycle(HSE, 0, 1'b1);
                    check_async_reset();
                    n = $urandom_range(0, 2);
                    for (int i = 0; i < n; i++) tx_cycle(HSE, 0, 1'b1);
                end
                5: begin
                    align_to(5);
                    tx_cycle(HSE, 2, 1'b0);
                end
                default: run_cycles($urandom_range(1, 3) * HT * VT);
            endcase
            $display("scenario %0d (kind %0d): locked=%0b compared=%0d", it, sc, lk_hi, n_cmp);
            run_cycles(3 * HT * VT + $urandom_range(0, HT));
        end

        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
